// File: rtl/div2_engine_if.sv
// Host-side handshake and byte-wide data-memory port of the divide engine.
// The host (master) owns Start and read data; the engine (slave) owns the rest.
interface div2_engine_if #(
    parameter int ADDR_W = 8
);
    logic              Start;
    logic              Ack;
    logic              Busy;
    logic [ADDR_W-1:0] Mem_Addr;
    logic              Mem_Re;
    logic [7:0]        Mem_Rdata;
    logic              Mem_We;
    logic [7:0]        Mem_Wdata;

    modport master (
        output Start, Mem_Rdata,
        input  Ack, Busy, Mem_Addr, Mem_Re, Mem_We, Mem_Wdata
    );

    modport slave (
        input  Start, Mem_Rdata,
        output Ack, Busy, Mem_Addr, Mem_Re, Mem_We, Mem_Wdata
    );
endinterface

// File: rtl/div2_engine.sv
// Start/Ack responder: reads a 16-bit dividend and 8-bit divisor from memory,
// writes back floor(dividend*256/divisor) as 24 bits (all ones for divisor 0).
//
// state | meaning
// IDLE  | waiting for Start high-to-low
// RD0   | read strobe, dividend MSB address
// RD1   | read strobe, dividend LSB address; capture dividend MSB
// RD2   | read strobe, divisor address; capture dividend LSB
// CAP   | capture divisor, seed the divider or short-circuit divide-by-zero
// DIV   | one restoring-divide step per cycle, 24 steps
// WR0-2 | write result MSB..LSB
// DONE  | Ack high until Start is seen high
module div2_engine #(
    parameter int ADDR_W    = 8,
    parameter int OPND_BASE = 0,
    parameter int RSLT_BASE = 4
) (
    input logic          Clk,
    input logic          Reset,
    div2_engine_if.slave bus
);

    typedef enum logic [3:0] {
        S_IDLE, S_RD0, S_RD1, S_RD2, S_CAP, S_DIV, S_WR0, S_WR1, S_WR2, S_DONE
    } state_t;

    localparam logic [ADDR_W-1:0] OPND0 = ADDR_W'(OPND_BASE);
    localparam logic [ADDR_W-1:0] OPND1 = ADDR_W'(OPND_BASE + 1);
    localparam logic [ADDR_W-1:0] OPND2 = ADDR_W'(OPND_BASE + 2);
    localparam logic [ADDR_W-1:0] RSLT0 = ADDR_W'(RSLT_BASE);
    localparam logic [ADDR_W-1:0] RSLT1 = ADDR_W'(RSLT_BASE + 1);
    localparam logic [ADDR_W-1:0] RSLT2 = ADDR_W'(RSLT_BASE + 2);

    state_t            state_q;
    logic              start_q;
    logic              ack_q;
    logic              busy_q;
    logic              re_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [7:0]        wdata_q;
    logic [15:0]       dvd_q;
    logic [7:0]        dvsr_q;
    logic [23:0]       num_q;
    logic [7:0]        rem_q;
    logic [23:0]       quo_q;
    logic [4:0]        cnt_q;

    logic [8:0]        rem_shift_d;
    logic              qbit_d;
    logic [8:0]        rem_d;
    logic [23:0]       quo_d;

    // The partial remainder always stays below the divisor, so 8 bits hold it
    // between steps; only the shifted value needs the ninth bit.
    always_comb begin
        rem_shift_d = {rem_q, num_q[23]};
        qbit_d      = (rem_shift_d >= {1'b0, dvsr_q});
        rem_d       = qbit_d ? (rem_shift_d - {1'b0, dvsr_q}) : rem_shift_d;
        quo_d       = {quo_q[22:0], qbit_d};
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= S_IDLE;
            start_q <= 1'b0;
            ack_q   <= 1'b0;
            busy_q  <= 1'b0;
            re_q    <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            dvd_q   <= '0;
            dvsr_q  <= '0;
            num_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            cnt_q   <= '0;
        end else begin
            start_q <= bus.Start;
            re_q    <= 1'b0;
            we_q    <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start_q && !bus.Start) begin
                        state_q <= S_RD0;
                        busy_q  <= 1'b1;
                        re_q    <= 1'b1;
                        addr_q  <= OPND0;
                    end
                end
                S_RD0: begin
                    state_q <= S_RD1;
                    re_q    <= 1'b1;
                    addr_q  <= OPND1;
                end
                S_RD1: begin
                    state_q     <= S_RD2;
                    re_q        <= 1'b1;
                    addr_q      <= OPND2;
                    dvd_q[15:8] <= bus.Mem_Rdata;
                end
                S_RD2: begin
                    state_q    <= S_CAP;
                    dvd_q[7:0] <= bus.Mem_Rdata;
                end
                S_CAP: begin
                    dvsr_q <= bus.Mem_Rdata;
                    if (bus.Mem_Rdata == 8'h00) begin
                        quo_q   <= 24'hFF_FFFF;
                        state_q <= S_WR0;
                        we_q    <= 1'b1;
                        addr_q  <= RSLT0;
                        wdata_q <= 8'hFF;
                    end else begin
                        num_q   <= {dvd_q, 8'h00};
                        rem_q   <= '0;
                        quo_q   <= '0;
                        cnt_q   <= 5'd23;
                        state_q <= S_DIV;
                    end
                end
                S_DIV: begin
                    rem_q <= rem_d[7:0];
                    quo_q <= quo_d;
                    num_q <= {num_q[22:0], 1'b0};
                    cnt_q <= cnt_q - 5'd1;
                    // Last step feeds the first write straight from the new quotient.
                    if (cnt_q == 5'd0) begin
                        state_q <= S_WR0;
                        we_q    <= 1'b1;
                        addr_q  <= RSLT0;
                        wdata_q <= quo_d[23:16];
                    end
                end
                S_WR0: begin
                    state_q <= S_WR1;
                    we_q    <= 1'b1;
                    addr_q  <= RSLT1;
                    wdata_q <= quo_q[15:8];
                end
                S_WR1: begin
                    state_q <= S_WR2;
                    we_q    <= 1'b1;
                    addr_q  <= RSLT2;
                    wdata_q <= quo_q[7:0];
                end
                S_WR2: begin
                    state_q <= S_DONE;
                    busy_q  <= 1'b0;
                    ack_q   <= 1'b1;
                end
                S_DONE: begin
                    if (bus.Start) begin
                        state_q <= S_IDLE;
                        ack_q   <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    ack_q   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.Ack       = ack_q;
    assign bus.Busy      = busy_q;
    assign bus.Mem_Re    = re_q;
    assign bus.Mem_We    = we_q;
    assign bus.Mem_Addr  = addr_q;
    assign bus.Mem_Wdata = wdata_q;

endmodule

// File: tb/tb_div2_engine.sv
// Bench for div2_engine: memory model, Start/Ack host driver, and an
// Ack-triggered monitor that checks results against a queue of expectations.
module tb_div2_engine;

    logic clk;
    logic rst_n;

    div2_engine_if #(.ADDR_W(8)) bus ();

    div2_engine dut (
        .Clk   (clk),
        .Reset (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [23:0] res;
        int          busy;
    } exp_t;

    exp_t        sb[$];
    logic [7:0]  mem[256];
    int          total;
    int          bad;
    int          busy_cnt;
    int          rd_cnt;
    int          wr_cnt;
    int          ovl_cnt;
    logic        ack_prev;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.Mem_Re) bus.Mem_Rdata <= mem[bus.Mem_Addr];
        if (bus.Mem_We) mem[bus.Mem_Addr] <= bus.Mem_Wdata;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, wanted %0h", name, act, exp);
        end
    endtask

    function automatic exp_t model(input logic [15:0] dvd, input logic [7:0] dvs);
        exp_t e;
        if (dvs == 8'd0) begin
            e.res  = 24'hFF_FFFF;
            e.busy = 7;
        end else begin
            e.res  = 24'((int'(dvd) * 256) / int'(dvs));
            e.busy = 31;
        end
        return e;
    endfunction

    // Monitor: tallies activity per run and checks the memory result on each Ack rise.
    initial begin
        exp_t e;
        ack_prev = 1'b0;
        busy_cnt = 0; rd_cnt = 0; wr_cnt = 0; ovl_cnt = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                busy_cnt = 0; rd_cnt = 0; wr_cnt = 0; ovl_cnt = 0;
                ack_prev = 1'b0;
            end else begin
                if (bus.Busy) busy_cnt++;
                if (bus.Mem_Re) rd_cnt++;
                if (bus.Mem_We) wr_cnt++;
                if (bus.Mem_Re && bus.Mem_We) ovl_cnt++;
                if (bus.Ack && !ack_prev) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_ack", 32'd1, 32'd0);
                    end else begin
                        e = sb.pop_front();
                        chk("result", {8'h00, mem[4], mem[5], mem[6]}, {8'h00, e.res});
                        chk("busy_cycles", busy_cnt, e.busy);
                        chk("read_count", rd_cnt, 3);
                        chk("write_count", wr_cnt, 3);
                        chk("re_we_overlap", ovl_cnt, 0);
                    end
                    busy_cnt = 0; rd_cnt = 0; wr_cnt = 0; ovl_cnt = 0;
                end
                ack_prev = bus.Ack;
            end
        end
    end

    // Start is high on entry; loads memory, drops Start, waits for Ack, raises Start.
    task automatic do_run(input logic [15:0] dvd, input logic [7:0] dvs, input bit pulse_mid);
        int i;
        @(negedge clk);
        bus.Start = 1'b1;
        mem[0] = dvd[15:8];
        mem[1] = dvd[7:0];
        mem[2] = dvs;
        mem[4] = 8'hA5; mem[5] = 8'hA5; mem[6] = 8'hA5;
        sb.push_back(model(dvd, dvs));
        @(negedge clk);
        bus.Start = 1'b0;
        if (pulse_mid) begin
            repeat (12) @(negedge clk);
            bus.Start = 1'b1;
            @(negedge clk);
            bus.Start = 1'b0;
        end
        i = 0;
        while (!bus.Ack && i < 100) begin
            @(negedge clk);
            i++;
        end
        chk("ack_seen", {31'd0, bus.Ack}, 32'd1);
        if (pulse_mid) begin
            repeat (3) @(negedge clk);
            chk("ack_held_after_pulse", {31'd0, bus.Ack}, 32'd1);
        end
        bus.Start = 1'b1;
        @(negedge clk);
        chk("ack_falls", {31'd0, bus.Ack}, 32'd0);
    endtask

    initial begin
        int quiet;
        logic [15:0] rd;
        logic [7:0]  rv;
        total = 0;
        bad   = 0;
        for (int k = 0; k < 256; k++) mem[k] = 8'h00;
        bus.Start     = 1'b1;
        bus.Mem_Rdata = 8'h00;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_outputs", {bus.Ack, bus.Busy, bus.Mem_Re, bus.Mem_We, bus.Mem_Addr, bus.Mem_Wdata},
            32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        do_run(16'h0009, 8'h08, 1'b0);
        do_run(16'h0003, 8'hFF, 1'b0);
        do_run(16'hFFFF, 8'h01, 1'b0);
        do_run(16'h0001, 8'h03, 1'b0);
        do_run(16'h1234, 8'h00, 1'b0);

        // Abort mid-divide and check the engine goes quiet.
        @(negedge clk);
        mem[0] = 8'h12; mem[1] = 8'h34; mem[2] = 8'h07;
        @(negedge clk);
        bus.Start = 1'b0;
        repeat (14) @(negedge clk);
        chk("pre_abort_busy", {31'd0, bus.Busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("abort_outputs", {bus.Ack, bus.Busy, bus.Mem_Re, bus.Mem_We, bus.Mem_Addr, bus.Mem_Wdata},
            32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        quiet = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.Mem_We || bus.Ack || bus.Busy || bus.Mem_Re) quiet++;
        end
        chk("post_abort_quiet", quiet, 0);
        do_run(16'h1234, 8'h07, 1'b0);

        do_run(16'h4321, 8'h09, 1'b1);
        do_run(16'h00FF, 8'h10, 1'b0);

        for (int n = 0; n < 500; n++) begin
            rd = 16'($urandom);
            rv = ($urandom_range(0, 15) == 0) ? 8'h00 : 8'($urandom);
            do_run(rd, rv, 1'b0);
        end

        repeat (5) @(negedge clk);
        chk("leftover_expect", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/div2_engine.md
Name: div2_engine

Overview:
- Hardware responder for the program-2 Start/Ack protocol: computes the 24-bit fixed-point quotient of a 16-bit dividend by an 8-bit divisor.
- Reads operands from the shared byte-wide data memory, runs a bit-serial restoring divide, writes the result back to memory, then raises Ack.
- Sits beside the CPU datapath on the data-memory port; the host loads memory, toggles Start, waits for Ack and reads the result.

Parameters:
ADDR_W, 8, data-memory address width
OPND_BASE, 0, address of dividend MSB; dividend LSB at +1, divisor at +2
RSLT_BASE, 4, address of result MSB; result bits [15:8] at +1, bits [7:0] at +2

Ports:
Clk  input  1  single clock, rising-edge
Reset  input  1  asynchronous, active-low reset
Start  input  1  launch request; host holds high while loading, launch on high-to-low transition
Ack  output  1  program run complete; level, held until next Start
Busy  output  1  high from launch until Ack
Mem_Addr  output  ADDR_W  data-memory byte address
Mem_Re  output  1  read strobe; memory returns Mem_Rdata one cycle later (synchronous read)
Mem_Rdata  input  8  read data
Mem_We  output  1  write strobe, one byte per asserted cycle
Mem_Wdata  output  8  write data

Behaviour:
- Reset (Reset=0, async): state IDLE; Ack=0, Busy=0, Mem_Re=0, Mem_We=0, Mem_Addr=0, Mem_Wdata=0; Start history register=0; datapath registers cleared.
- Start edge detect: start_q registers Start every cycle. Launch = IDLE & start_q & ~Start at a rising edge (edge E0). Start held high across reset release and then dropped launches. Start held low after reset does not launch.
- States, one cycle each unless noted:
  - IDLE -> RD0 on launch.
  - RD0: Mem_Re=1, addr OPND_BASE.
  - RD1: Mem_Re=1, addr OPND_BASE+1; capture dividend[15:8].
  - RD2: Mem_Re=1, addr OPND_BASE+2; capture dividend[7:0].
  - CAP: capture divisor.
    - Divisor 0: quotient=24'hFFFFFF, go to WR0.
    - Otherwise load N={dividend,8'h00}, remainder R=9'd0, count=23, go to DIV.
  - DIV, 24 cycles: R'={R[7:0],N[23]}; if R'>=divisor then R'-=divisor and the quotient bit is 1; shift the quotient bit into Q LSB and shift N left. Exit to WR0 after the count-0 cycle.
  - WR0/WR1/WR2: Mem_We=1. Addr RSLT_BASE+0/1/2. Data Q[23:16]/Q[15:8]/Q[7:0].
  - DONE: Ack=1. Exit to IDLE (Ack=0) at the first edge that samples Start=1.
- Result = floor(dividend*256/divisor), truncated with no rounding. This never overflows 24 bits: the maximum is 0xFFFF00.
- Latency: DONE is entered at E0+31 for a nonzero divisor and at E0+7 for a zero divisor. RD0 is entered at E0.
- Busy=1 in every state from RD0 through WR2. Busy=0 in IDLE and DONE.
- Mem_Re and Mem_We are never high together. Both are 0 outside the listed states. Mem_Addr holds its last value when neither strobe is high.
- Start activity while Busy is ignored, including a complete high-low pulse, and is not queued.
- Reset mid-operation: immediate return to IDLE. No partial writes occur after reset asserts, and Ack stays 0.
- Back-to-back runs: host raises Start (DONE->IDLE), reloads memory, then drops Start; the next run launches normally. Operand registers are reloaded each run and nothing carries over.

Test Plan:
- Memory[0..2]=00,09,08; pulse Start -> Ack at E0+31; memory[4..6]=00,01,20 (0x000120); exactly 3 writes and 3 reads observed.
- Dividend 0x0003, divisor 0xFF -> result 0x000003; dividend 0xFFFF, divisor 0x01 -> 0xFFFF00; dividend 0x0001, divisor 0x03 -> 0x000055.
- Divisor 0 with any dividend (0x1234) -> result 0xFFFFFF; Ack at E0+7; no DIV cycles (Busy high exactly 7 cycles).
- Assert Reset during DIV cycle 10 -> all outputs 0 at once; no Mem_We afterwards; Ack stays 0; next Start pulse computes correctly from scratch.
- Full Start pulse during DIV -> ignored; single Ack at E0+31. Raise Start in DONE -> Ack falls next edge. Second run 0x00FF/0x10 -> 0x000FF0.
- Random sweep: 500 runs of random dividend/divisor checked against floor(dividend*256/divisor), or 0xFFFFFF for divisor 0; Mem_Re and Mem_We never coincide.
